// File: rtl/mem_ctrl_param.sv
// Parametrised single-port scratch memory: post-reset init sweep, bit-masked writes,
// 1- or 2-cycle read latency with a valid strobe, and out-of-range / read-write conflict flags.
module mem_ctrl_param #(
    parameter int                DATA_W   = 21,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              rden,
    input  logic              wren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ready,
    output logic              addr_err,
    output logic              rw_conflict
);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("mem_ctrl_param: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("mem_ctrl_param: DEPTH must be in 1..2**ADDR_W");
    end

    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, acc_rd, acc_wr, in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd, rd_word;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            S_INIT:  if (cnt == LAST) state_nxt = S_RUN;
            S_RUN:   ready = 1'b1;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT && cnt != LAST) cnt <= cnt + ADDR_W'(1);
        end
    end

    // Read wins a read/write collision; the write is dropped
    always_comb begin
        in_range = {1'b0, addr} < DEPTH_X;
        accept   = rst_n & ready & ce & (rden | wren);
        acc_rd   = accept & rden;
        acc_wr   = accept & wren & ~rden;
        rd_word  = in_range ? mem[addr] : '0;
        mem_we   = 1'b0;
        mem_wa   = addr;
        mem_wd   = '0;
        if (state == S_INIT) begin
            mem_we = rst_n;
            mem_wa = cnt;
            mem_wd = INIT_VAL;
        end else if (acc_wr && in_range) begin
            mem_we = 1'b1;
            mem_wd = (mem[addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // stage p0: optional extra read register for RD_LAT = 2
    if (RD_LAT == 2) begin : g_lat2
        logic              vld_p0;
        logic [DATA_W-1:0] data_p0;

        always_ff @(posedge clk) begin
            if (!rst_n) vld_p0 <= 1'b0;
            else        vld_p0 <= acc_rd;
            if (acc_rd) data_p0 <= rd_word;
        end

        assign vld_p1  = vld_p0;
        assign data_p1 = data_p0;
    end else begin : g_lat1
        assign vld_p1  = acc_rd;
        assign data_p1 = rd_word;
    end

    // stage p1: output registers; rd_data only changes when a result arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            addr_err    <= 1'b0;
            rw_conflict <= 1'b0;
        end else begin
            rd_valid    <= vld_p1;
            if (vld_p1) rd_data <= data_p1;
            addr_err    <= accept & ~in_range;
            rw_conflict <= accept & rden & wren;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Bench for mem_ctrl_param: a default instance (A) and an RD_LAT=2 / DEPTH=200 /
// INIT_VAL=0x155555 instance (B), with a per-instance read scoreboard.
module tb_mem_ctrl_param;

    localparam logic [20:0] INIT_B = 21'h155555;
    localparam logic [20:0] ALL    = 21'h1FFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst_na, ce_a, rden_a, wren_a;
    logic [7:0]  addr_a;
    logic [20:0] wdata_a, wmask_a, rd_data_a;
    logic        rd_valid_a, ready_a, addr_err_a, rw_conflict_a;

    logic        rst_nb, ce_b, rden_b, wren_b;
    logic [7:0]  addr_b;
    logic [20:0] wdata_b, wmask_b, rd_data_b;
    logic        rd_valid_b, ready_b, addr_err_b, rw_conflict_b;

    mem_ctrl_param dut_a (
        .clk(clk), .rst_n(rst_na), .ce(ce_a), .rden(rden_a), .wren(wren_a),
        .addr(addr_a), .wr_data(wdata_a), .wr_mask(wmask_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .ready(ready_a), .addr_err(addr_err_a), .rw_conflict(rw_conflict_a)
    );

    mem_ctrl_param #(.DATA_W(21), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .INIT_VAL(INIT_B)) dut_b (
        .clk(clk), .rst_n(rst_nb), .ce(ce_b), .rden(rden_b), .wren(wren_b),
        .addr(addr_b), .wr_data(wdata_b), .wr_mask(wmask_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .ready(ready_b), .addr_err(addr_err_b), .rw_conflict(rw_conflict_b)
    );

    typedef struct {
        logic [20:0] data;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        mon_a, mon_b;
    logic [20:0] mdl_a [256];
    logic [20:0] mdl_b [256];
    bit          live_a = 1'b0;
    bit          live_b = 1'b0;

    always @(negedge clk) begin
        if (rd_valid_a === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rdA_unexpected rd_valid=1 rd_data=%h at cycle %0d, expected no read result", rd_data_a, cyc);
            end else begin
                mon_a = q_a.pop_front();
                if (rd_data_a !== mon_a.data || cyc != mon_a.due) begin
                    errors++;
                    $display("FAIL rdA_data got %h at cycle %0d, expected %h at cycle %0d", rd_data_a, cyc, mon_a.data, mon_a.due);
                end
            end
        end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
            checks++;
            errors++;
            mon_a = q_a.pop_front();
            $display("FAIL rdA_missing rd_valid=0 at cycle %0d, expected %h at cycle %0d", cyc, mon_a.data, mon_a.due);
        end
    end

    always @(negedge clk) begin
        if (rd_valid_b === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL rdB_unexpected rd_valid=1 rd_data=%h at cycle %0d, expected no read result", rd_data_b, cyc);
            end else begin
                mon_b = q_b.pop_front();
                if (rd_data_b !== mon_b.data || cyc != mon_b.due) begin
                    errors++;
                    $display("FAIL rdB_data got %h at cycle %0d, expected %h at cycle %0d", rd_data_b, cyc, mon_b.data, mon_b.due);
                end
            end
        end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
            checks++;
            errors++;
            mon_b = q_b.pop_front();
            $display("FAIL rdB_missing rd_valid=0 at cycle %0d, expected %h at cycle %0d", cyc, mon_b.data, mon_b.due);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request on instance b=0 (A) or b=1 (B); accepted reads are scoreboarded
    task automatic drv(input bit b, input logic c, input logic r, input logic w,
                       input logic [7:0] a, input logic [20:0] d, input logic [20:0] m);
        exp_t e;
        @(negedge clk);
        if (!b) begin
            ce_a = c; rden_a = r; wren_a = w; addr_a = a; wdata_a = d; wmask_a = m;
            if (c && live_a) begin
                if (r) begin
                    e.data = mdl_a[a];
                    e.due  = cyc + 1;
                    q_a.push_back(e);
                end else if (w) begin
                    mdl_a[a] = (mdl_a[a] & ~m) | (d & m);
                end
            end
        end else begin
            ce_b = c; rden_b = r; wren_b = w; addr_b = a; wdata_b = d; wmask_b = m;
            if (c && live_b) begin
                if (r) begin
                    e.data = (a < 8'd200) ? mdl_b[a] : 21'h0;
                    e.due  = cyc + 2;
                    q_b.push_back(e);
                end else if (w && a < 8'd200) begin
                    mdl_b[a] = (mdl_b[a] & ~m) | (d & m);
                end
            end
        end
    endtask

    task automatic idle(input bit b);
        @(negedge clk);
        if (!b) begin ce_a = 1'b0; rden_a = 1'b0; wren_a = 1'b0; end
        else    begin ce_b = 1'b0; rden_b = 1'b0; wren_b = 1'b0; end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending A=%0d B=%0d, expected 0", q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic test_reset_a();
        int c0, n;
        rst_na = 1'b0; ce_a = 1'b0; rden_a = 1'b0; wren_a = 1'b0;
        addr_a = '0; wdata_a = '0; wmask_a = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready_a, rd_valid_a, addr_err_a, rw_conflict_a} !== 4'b0000) begin
            errors++;
            $display("FAIL resetA_ctrl ready/vld/err/conf=%b expected 0000", {ready_a, rd_valid_a, addr_err_a, rw_conflict_a});
        end
        checks++;
        if (rd_data_a !== 21'h0) begin errors++; $display("FAIL resetA_rd_data got %h expected 000000", rd_data_a); end
        rst_na = 1'b1;
        c0 = cyc;
        foreach (mdl_a[i]) mdl_a[i] = 21'h0;
        n = 0;
        while (ready_a !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (cyc - c0 != 256) begin errors++; $display("FAIL readyA_delay got %0d cycles expected 256", cyc - c0); end
        live_a = 1'b1;
        drv(0, 1, 1, 0, 8'h00, 21'h0, 21'h0);
        drv(0, 1, 1, 0, 8'h7F, 21'h0, 21'h0);
        drv(0, 1, 1, 0, 8'hFF, 21'h0, 21'h0);
        idle(0);
        drain();
    endtask

    task automatic test_masked_write();
        drv(0, 1, 0, 1, 8'h10, 21'h1FFFFF, ALL);
        idle(0);
        checks++;
        if (addr_err_a !== 1'b0 || rw_conflict_a !== 1'b0) begin
            errors++;
            $display("FAIL mask_flags err=%b conf=%b expected 0 0", addr_err_a, rw_conflict_a);
        end
        drv(0, 1, 1, 0, 8'h10, 21'h0, 21'h0);
        drv(0, 1, 0, 1, 8'h10, 21'h000000, 21'h0000FF);
        drv(0, 1, 1, 0, 8'h10, 21'h0, 21'h0);
        drv(0, 1, 0, 1, 8'h10, 21'h0AAAAA, 21'h000000);
        drv(0, 1, 1, 0, 8'h10, 21'h0, 21'h0);
        idle(0);
        drain();
    endtask

    task automatic test_conflict();
        drv(0, 1, 0, 1, 8'h20, 21'h0ABCDE, ALL);
        idle(0);
        drv(0, 1, 1, 1, 8'h20, 21'h123456, ALL);
        idle(0);
        checks++;
        if (rw_conflict_a !== 1'b1) begin errors++; $display("FAIL conflict_pulse got %b expected 1", rw_conflict_a); end
        checks++;
        if (addr_err_a !== 1'b0) begin errors++; $display("FAIL conflict_addr_err got %b expected 0", addr_err_a); end
        @(negedge clk);
        checks++;
        if (rw_conflict_a !== 1'b0) begin errors++; $display("FAIL conflict_width got %b expected 0", rw_conflict_a); end
        drv(0, 1, 1, 0, 8'h20, 21'h0, 21'h0);
        idle(0);
        drain();
    endtask

    task automatic test_ce();
        drv(0, 0, 1, 0, 8'h10, 21'h0, 21'h0);
        idle(0);
        checks++;
        if ({rd_valid_a, addr_err_a, rw_conflict_a} !== 3'b000) begin
            errors++;
            $display("FAIL ce_read vld/err/conf=%b expected 000", {rd_valid_a, addr_err_a, rw_conflict_a});
        end
        drv(0, 0, 0, 1, 8'h10, 21'h000000, ALL);
        idle(0);
        drv(0, 1, 1, 0, 8'h10, 21'h0, 21'h0);
        idle(0);
        drain();
        repeat (3) @(negedge clk);
        checks++;
        if (rd_data_a !== 21'h1FFF00 || rd_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_rd_data got %h vld=%b expected 1fff00 vld=0", rd_data_a, rd_valid_a);
        end
    endtask

    task automatic test_reset_b();
        int c0, n;
        rst_nb = 1'b0; ce_b = 1'b0; rden_b = 1'b0; wren_b = 1'b0;
        addr_b = '0; wdata_b = '0; wmask_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready_b, rd_valid_b, addr_err_b, rw_conflict_b} !== 4'b0000 || rd_data_b !== 21'h0) begin
            errors++;
            $display("FAIL resetB ctrl=%b rd_data=%h expected 0000 000000", {ready_b, rd_valid_b, addr_err_b, rw_conflict_b}, rd_data_b);
        end
        rst_nb = 1'b1;
        c0 = cyc;
        foreach (mdl_b[i]) mdl_b[i] = INIT_B;
        n = 0;
        while (ready_b !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (cyc - c0 != 200) begin errors++; $display("FAIL readyB_delay got %0d cycles expected 200", cyc - c0); end
        live_b = 1'b1;
        drv(1, 1, 1, 0, 8'h00, 21'h0, 21'h0);
        idle(1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [20:0] vals [4] = '{21'h11, 21'h22, 21'h33, 21'h44};
        for (int i = 0; i < 4; i++) drv(1, 1, 0, 1, 8'(i + 1), vals[i], ALL);
        idle(1);
        for (int i = 0; i < 4; i++) drv(1, 1, 1, 0, 8'(i + 1), 21'h0, 21'h0);
        idle(1);
        drain();
    endtask

    task automatic test_out_of_range();
        drv(1, 1, 0, 1, 8'hC8, 21'h1FFFFF, ALL);
        idle(1);
        checks++;
        if (addr_err_b !== 1'b1) begin errors++; $display("FAIL oor_write_err got %b expected 1", addr_err_b); end
        @(negedge clk);
        checks++;
        if (addr_err_b !== 1'b0) begin errors++; $display("FAIL oor_err_width got %b expected 0", addr_err_b); end
        drv(1, 1, 1, 0, 8'hC7, 21'h0, 21'h0);
        drv(1, 1, 1, 0, 8'h00, 21'h0, 21'h0);
        drv(1, 1, 1, 0, 8'h01, 21'h0, 21'h0);
        idle(1);
        drain();
        drv(1, 1, 1, 0, 8'hFF, 21'h0, 21'h0);
        idle(1);
        checks++;
        if (addr_err_b !== 1'b1) begin errors++; $display("FAIL oor_read_err got %b expected 1", addr_err_b); end
        drain();
    endtask

    task automatic test_reset_mid();
        int c0, n;
        drv(1, 1, 0, 1, 8'h05, 21'h0F0F0F, ALL);
        drv(1, 1, 1, 0, 8'h05, 21'h0, 21'h0);
        idle(1);
        drain();
        live_b = 1'b0;
        drv(1, 1, 1, 0, 8'h05, 21'h0, 21'h0);
        @(negedge clk);
        rst_nb = 1'b0; ce_b = 1'b0; rden_b = 1'b0; wren_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_b, rd_valid_b} !== 2'b00 || rd_data_b !== 21'h0) begin
            errors++;
            $display("FAIL midreset ready/vld=%b rd_data=%h expected 00 000000", {ready_b, rd_valid_b}, rd_data_b);
        end
        @(negedge clk);
        rst_nb = 1'b1;
        c0 = cyc;
        foreach (mdl_b[i]) mdl_b[i] = INIT_B;
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, (i != 1), (i != 0 && i != 3), (i == 3) ? 8'hFF : 8'h05, 21'h0, ALL);
            idle(1);
            checks++;
            if (addr_err_b !== 1'b0 || rw_conflict_b !== 1'b0) begin
                errors++;
                $display("FAIL init_ignore op%0d err=%b conf=%b expected 0 0", i, addr_err_b, rw_conflict_b);
            end
        end
        n = 0;
        while (ready_b !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (cyc - c0 != 200) begin errors++; $display("FAIL readyB_redelay got %0d cycles expected 200", cyc - c0); end
        live_b = 1'b1;
        drv(1, 1, 1, 0, 8'h05, 21'h0, 21'h0);
        drv(1, 1, 1, 0, 8'h00, 21'h0, 21'h0);
        idle(1);
        drain();
    endtask

    initial begin
        rst_nb = 1'b0; ce_b = 1'b0; rden_b = 1'b0; wren_b = 1'b0;
        addr_b = '0; wdata_b = '0; wmask_b = '0;
        test_reset_a();
        test_masked_write();
        test_conflict();
        test_ce();
        test_reset_b();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_param.md
Name: mem_ctrl_param

Overview:
- Parametrised successor to the subsystem's single-port 21-bit × 256 scratch memory.
- Adds a post-reset initialisation sweep, a ready gate, and a bit-level write mask.
- Adds configurable read latency with an rd_valid strobe, plus out-of-range and read/write-conflict flags.
- Sits between the simple processor's load/store path and its data storage; it is a drop-in replacement when parameters are left at their defaults.

Parameters:
- DATA_W, 21, word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2. Any other value is a static elaboration error.
- INIT_VAL, 0, DATA_W-bit value written to every word during the init sweep.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ce  in  1  chip enable; the request is ignored when low.
- rden  in  1  read request.
- wren  in  1  write request.
- addr  in  ADDR_W  word address.
- wr_data  in  DATA_W  write data.
- wr_mask  in  DATA_W  per-bit write enable; 1 = update that bit.
- rd_data  out  DATA_W  read data; holds its value between reads.
- rd_valid  out  1  one-cycle strobe marking new rd_data.
- ready  out  1  high when requests are accepted.
- addr_err  out  1  one-cycle pulse when an accepted request has addr ≥ DEPTH.
- rw_conflict  out  1  one-cycle pulse when rden and wren are both high on an accepted cycle.

Behaviour:
- Reset (rst_n low at a clk edge), values on the following cycle:
  - rd_data = 0, rd_valid = 0, ready = 0, addr_err = 0, rw_conflict = 0.
  - The read pipeline is flushed and the sweep counter is cleared to 0.
  - FSM enters INIT.
- FSM has two states: INIT and RUN.
- INIT:
  - Each cycle writes INIT_VAL to mem[cnt], then increments cnt.
  - After writing word DEPTH-1, FSM moves to RUN; ready rises on the next cycle.
  - ready goes high exactly DEPTH cycles after the first cycle with rst_n high.
  - All requests during INIT are ignored: no flags, no rd_valid.
- RUN: ready = 1, and the FSM stays in RUN until reset.
- Acceptance: a request is accepted on a clk edge where ready & ce & (rden | wren).
- Priority: when rden and wren are both high, the read wins, the write is dropped, and rw_conflict pulses on the next cycle.
- Read, in range:
  - RD_LAT=1: rd_data = mem[addr] and rd_valid = 1 in the cycle after acceptance.
  - RD_LAT=2: one extra pipeline register, so rd_data and rd_valid appear 2 cycles after acceptance.
  - Back-to-back reads are accepted every cycle, giving 1 result per cycle in order.
- Read, addr ≥ DEPTH: returns rd_data = 0 with rd_valid at the normal latency; addr_err pulses 1 cycle after acceptance.
- Write, in range: mem[addr] <= (mem[addr] & ~wr_mask) | (wr_data & wr_mask). wr_mask = 0 leaves the word unchanged but is still an accepted write.
- Write, addr ≥ DEPTH: memory is unchanged; addr_err pulses 1 cycle after acceptance.
- Write then read of the same address on the next cycle returns the new data. There is no same-cycle bypass, because the read wins.
- rd_valid is 0 on every cycle not carrying a read result; rd_data is never cleared except by reset.
- Reset mid-operation:
  - In-flight reads are discarded and never produce rd_valid.
  - The sweep restarts from word 0, and the memory is re-initialised to INIT_VAL.
- ce low with rden or wren high: nothing is accepted and no flags fire.

Test Plan:
- Reset/init, defaults: hold rst_n=0 for 3 cycles, then release → ready=0 for exactly 256 cycles, then 1. Reading addr 0x00, 0x7F and 0xFF each returns 0x000000 with rd_valid 1 cycle later.
- Masked write, defaults:
  - Write addr 0x10, data 0x1FFFFF, mask 0x1FFFFF → word = 0x1FFFFF.
  - Write data 0x000000, mask 0x0000FF → read returns 0x1FFF00.
  - Write with mask 0 → read still returns 0x1FFF00.
- Latency and streaming, RD_LAT=2:
  - Preload addresses 1..4 with 0x11, 0x22, 0x33, 0x44.
  - Issue 4 back-to-back reads → rd_valid high on 4 consecutive cycles, starting 2 cycles after the first read.
  - Data arrives in order 0x11, 0x22, 0x33, 0x44.
- Conflict and ce:
  - Set addr 0x20 = 0x0ABCDE. Assert rden=wren=1 at addr 0x20 with wr_data 0x123456 → rd_data = 0x0ABCDE, rw_conflict pulses, and a later read still gives 0x0ABCDE.
  - Drive ce=0 with rden=1 → no rd_valid.
- Out-of-range, DEPTH=200, ADDR_W=8:
  - Write addr 0xC8 → addr_err pulses and no word changes.
  - Read addr 0xFF → rd_data = 0 with rd_valid, and addr_err pulses.
- Reset mid-operation, INIT_VAL=0x155555:
  - Write addr 5 = 0x0F0F0F, then issue a read and assert rst_n=0 on the next cycle → no rd_valid for that read.
  - After re-init, addr 5 reads 0x155555.
  - Requests issued during INIT produce no response or flags.
